// File: rtl/decode_pkg.sv
// Shared decode constants and the registered control bundle type.
package decode_pkg;

    localparam int unsigned MULT_CNT_W = 4;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned ALU_W      = 3;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_MULT = 6'b011001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_JR   = 6'b001000;

    // ALU operation encoding
    localparam logic [ALU_W-1:0] ALU_SLT  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_MFLO = 3'b010;
    localparam logic [ALU_W-1:0] ALU_MFHI = 3'b011;
    localparam logic [ALU_W-1:0] ALU_MULT = 3'b100;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'b111;

    typedef struct packed {
        logic             regwrite;
        logic             memwrite;
        logic             memtoreg;
        logic             alusrcbimm;
        logic             isbranch;
        logic             branchne;
        logic             dojump;
        logic             jumpreg;
        logic             link;
        logic             luiimm;
        logic             illegal;
        logic [REG_W-1:0] destreg;
        logic [ALU_W-1:0] alucontrol;
    } ctl_t;

endpackage

// File: rtl/mult_scoreboard.sv
// Countdown of cycles remaining on the in-flight multiply.
module mult_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    logic [MULT_CNT_W-1:0] mcnt;

    // Load on multiply issue, otherwise count down to zero and stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt <= '0;
        end else if (load) begin
            mcnt <= MULT_CNT_W'(MULT_CYCLES);
        end else if (mcnt != '0) begin
            mcnt <= mcnt - MULT_CNT_W'(1);
        end
    end

    assign busy = (mcnt != '0);

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and multiply stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned LINK_REG    = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regwrite,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        alusrcbimm,
    output logic        isbranch,
    output logic        branchne,
    output logic        dojump,
    output logic        jumpreg,
    output logic        link,
    output logic        luiimm,
    output logic [4:0]  destreg,
    output logic [2:0]  alucontrol,
    output logic        illegal
);

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_fields;
    logic             is_mult;
    logic             is_mulop;
    logic             busy;
    logic             stall;
    logic             accept;
    ctl_t             dec;
    ctl_t             ctl_q;

    assign op            = instr[31:26];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign funct         = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    assign is_mult  = (op == OP_RTYPE) && (funct == F_MULT);
    assign is_mulop = (op == OP_RTYPE) &&
                      ((funct == F_MULT) || (funct == F_MFLO) || (funct == F_MFHI));
    assign stall    = busy & is_mulop;
    assign in_ready = (~out_valid | out_ready) & ~stall;
    assign accept   = in_valid & in_ready;

    mult_scoreboard #(.MULT_CYCLES(MULT_CYCLES)) u_sb (
        .clk   (clk),
        .reset (reset),
        .load  (accept & is_mult),
        .busy  (busy)
    );

    // Combinational decode of the presented instruction; unknowns collapse to a clean illegal bundle.
    always_comb begin
        dec            = '0;
        dec.alucontrol = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                dec.regwrite = 1'b1;
                dec.destreg  = rd;
                case (funct)
                    F_ADDU: dec.alucontrol = ALU_ADD;
                    F_SUBU: dec.alucontrol = ALU_SUB;
                    F_AND:  dec.alucontrol = ALU_AND;
                    F_OR:   dec.alucontrol = ALU_OR;
                    F_SLTU: dec.alucontrol = ALU_SLT;
                    F_MFHI: dec.alucontrol = ALU_MFHI;
                    F_MFLO: dec.alucontrol = ALU_MFLO;
                    F_MULT: begin
                        dec.alucontrol = ALU_MULT;
                        dec.regwrite   = 1'b0;
                    end
                    F_JR: begin
                        dec.regwrite = 1'b0;
                        dec.dojump   = 1'b1;
                        dec.jumpreg  = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                dec.regwrite   = 1'b1;
                dec.memtoreg   = 1'b1;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
            end
            OP_SW: begin
                dec.memwrite   = 1'b1;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
            end
            OP_BEQ, OP_BNE: begin
                dec.isbranch   = 1'b1;
                dec.branchne   = op[0];
                dec.alucontrol = ALU_SUB;
                dec.destreg    = rt;
            end
            OP_ADDIU, OP_ORI, OP_LUI: begin
                dec.regwrite   = 1'b1;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
                dec.luiimm     = (op == OP_LUI);
                dec.alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            OP_J: dec.dojump = 1'b1;
            OP_JAL: begin
                dec.dojump   = 1'b1;
                dec.link     = 1'b1;
                dec.regwrite = 1'b1;
                dec.destreg  = REG_W'(LINK_REG);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec            = '0;
            dec.illegal    = 1'b1;
            dec.alucontrol = ALU_ADD;
        end
    end

    // Output register: load on accept, drop valid on consume, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            ctl_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctl_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign regwrite   = ctl_q.regwrite;
    assign memwrite   = ctl_q.memwrite;
    assign memtoreg   = ctl_q.memtoreg;
    assign alusrcbimm = ctl_q.alusrcbimm;
    assign isbranch   = ctl_q.isbranch;
    assign branchne   = ctl_q.branchne;
    assign dojump     = ctl_q.dojump;
    assign jumpreg    = ctl_q.jumpreg;
    assign link       = ctl_q.link;
    assign luiimm     = ctl_q.luiimm;
    assign illegal    = ctl_q.illegal;
    assign destreg    = ctl_q.destreg;
    assign alucontrol = ctl_q.alucontrol;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed plan plus randomized traffic against a behavioural model.
module tb_decode_stage;

    localparam int MC = 4;

    typedef struct packed {
        logic       regwrite, memwrite, memtoreg, alusrcbimm, isbranch, branchne;
        logic       dojump, jumpreg, link, luiimm, illegal;
        logic [4:0] destreg;
        logic [2:0] alu;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        regwrite, memwrite, memtoreg, alusrcbimm, isbranch, branchne;
    logic        dojump, jumpreg, link, luiimm, illegal;
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.MULT_CYCLES(MC), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .regwrite(regwrite), .memwrite(memwrite),
        .memtoreg(memtoreg), .alusrcbimm(alusrcbimm), .isbranch(isbranch), .branchne(branchne),
        .dojump(dojump), .jumpreg(jumpreg), .link(link), .luiimm(luiimm), .destreg(destreg),
        .alucontrol(alucontrol), .illegal(illegal)
    );

    ctl_t dut_ctl;
    assign dut_ctl = {regwrite, memwrite, memtoreg, alusrcbimm, isbranch, branchne,
                      dojump, jumpreg, link, luiimm, illegal, destreg, alucontrol};

    // Reference decode, straight from the instruction table.
    function automatic ctl_t ref_decode(input logic [31:0] w);
        ctl_t c;
        logic bad;
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        c = '0;
        c.alu = 3'b101;
        bad = 1'b0;
        case (op)
            6'h00: begin
                c.regwrite = 1'b1;
                c.destreg  = w[15:11];
                case (fn)
                    6'h21: c.alu = 3'b101;
                    6'h23: c.alu = 3'b001;
                    6'h24: c.alu = 3'b111;
                    6'h25: c.alu = 3'b110;
                    6'h2B: c.alu = 3'b000;
                    6'h10: c.alu = 3'b011;
                    6'h12: c.alu = 3'b010;
                    6'h19: begin c.alu = 3'b100; c.regwrite = 1'b0; end
                    6'h08: begin c.regwrite = 1'b0; c.dojump = 1'b1; c.jumpreg = 1'b1; end
                    default: bad = 1'b1;
                endcase
            end
            6'h23: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.alusrcbimm = 1'b1; c.destreg = w[20:16]; end
            6'h2B: begin c.memwrite = 1'b1; c.alusrcbimm = 1'b1; c.destreg = w[20:16]; end
            6'h04: begin c.isbranch = 1'b1; c.alu = 3'b001; c.destreg = w[20:16]; end
            6'h05: begin c.isbranch = 1'b1; c.branchne = 1'b1; c.alu = 3'b001; c.destreg = w[20:16]; end
            6'h09: begin c.regwrite = 1'b1; c.alusrcbimm = 1'b1; c.destreg = w[20:16]; end
            6'h0D: begin c.regwrite = 1'b1; c.alusrcbimm = 1'b1; c.alu = 3'b110; c.destreg = w[20:16]; end
            6'h0F: begin c.regwrite = 1'b1; c.alusrcbimm = 1'b1; c.luiimm = 1'b1; c.destreg = w[20:16]; end
            6'h02: c.dojump = 1'b1;
            6'h03: begin c.dojump = 1'b1; c.link = 1'b1; c.regwrite = 1'b1; c.destreg = 5'd31; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c = '0;
            c.illegal = 1'b1;
            c.alu = 3'b101;
        end
        return c;
    endfunction

    function automatic logic is_mulop(input logic [31:0] w);
        return (w[31:26] == 6'h00) && (w[5:0] == 6'h19 || w[5:0] == 6'h12 || w[5:0] == 6'h10);
    endfunction

    // Model state: bundle, valid, and absolute cycle from which multiply-class ops may issue.
    int   cyc = 0;
    int   mult_ok_from = 0;
    logic started = 1'b0;
    logic m_valid = 1'b0;
    ctl_t m_ctl = '0;

    function automatic logic model_ready();
        return (!m_valid || out_ready) && !(is_mulop(instr) && cyc < mult_ok_from);
    endfunction

    // Model update at each rising edge.
    always begin
        @(posedge clk);
        if (reset) begin
            started      = 1'b1;
            m_valid      = 1'b0;
            m_ctl        = '0;
            mult_ok_from = 0;
        end else if (started) begin
            if (in_valid && model_ready()) begin
                m_ctl   = ref_decode(instr);
                m_valid = 1'b1;
                if (instr[31:26] == 6'h00 && instr[5:0] == 6'h19) mult_ok_from = cyc + MC + 1;
            end else if (out_ready && m_valid) begin
                m_valid = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always begin
        @(negedge clk);
        #1;
        if (started) begin
            n_cmp = n_cmp + 1;
            if (in_ready !== model_ready()) begin
                n_bad = n_bad + 1;
                $display("FAIL model_in_ready cyc=%0d instr=%h got %b want %b", cyc, instr, in_ready, model_ready());
            end
            n_cmp = n_cmp + 1;
            if (out_valid !== m_valid) begin
                n_bad = n_bad + 1;
                $display("FAIL model_out_valid cyc=%0d got %b want %b", cyc, out_valid, m_valid);
            end
            n_cmp = n_cmp + 1;
            if (dut_ctl !== m_ctl) begin
                n_bad = n_bad + 1;
                $display("FAIL model_bundle cyc=%0d got %h want %h", cyc, dut_ctl, m_ctl);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] w, input logic o);
        @(posedge clk);
        #1;
        reset     = r;
        in_valid  = v;
        instr     = w;
        out_ready = o;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    localparam logic [5:0] FN_TAB [9] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h19, 6'h10, 6'h12, 6'h08};
    localparam logic [5:0] OP_TAB [9] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h09, 6'h0D, 6'h0F, 6'h02, 6'h03};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 19);
        if (k < 9) begin
            r[31:26] = 6'h00;
            r[5:0]   = FN_TAB[k];
        end else if (k < 18) begin
            r[31:26] = OP_TAB[k - 9];
        end else if (k == 18) begin
            r[31:26] = 6'h00;
        end
        return r;
    endfunction

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_MULT = 32'h00220019;
    localparam logic [31:0] I_MFLO = 32'h00002012;
    localparam logic [31:0] I_LW   = 32'h8C250004;
    localparam logic [31:0] I_SW   = 32'hAC250004;
    localparam logic [31:0] I_BNE  = 32'h14220003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_BAD1 = 32'h7C000000;
    localparam logic [31:0] I_BAD2 = 32'h0000003F;

    initial begin
        int stalled;
        logic got;
        ctl_t t;

        // Pin the reference decode on hand-computed values.
        t = ref_decode(I_ADDU);
        chk("ref_addu", {t.regwrite, t.destreg, t.alu, t.illegal}, {1'b1, 5'd3, 3'b101, 1'b0});
        t = ref_decode(I_JAL);
        chk("ref_jal", {t.dojump, t.link, t.regwrite, t.destreg}, {1'b1, 1'b1, 1'b1, 5'd31});

        // Reset and first cycle afterwards
        drive(1, 0, 32'h0, 1);
        drive(1, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 1);
        sample();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_bundle", dut_ctl, 0);

        // addu
        drive(0, 1, I_ADDU, 1);
        drive(0, 0, 32'h0, 1);
        sample();
        chk("addu_valid", out_valid, 1);
        chk("addu_fields", {destreg, alucontrol, regwrite, illegal}, {5'd3, 3'b101, 1'b1, 1'b0});

        // mult then mflo held valid until accepted
        drive(0, 1, I_MULT, 1);
        stalled = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 1, I_MFLO, 1);
            sample();
            if (in_ready) got = 1'b1;
            else stalled++;
        end
        chk("mflo_accepted", got, 1);
        chk("mflo_stall_cycles", stalled, MC);
        drive(0, 0, 32'h0, 1);
        sample();
        chk("mflo_bundle", {out_valid, alucontrol, destreg}, {1'b1, 3'b010, 5'd4});

        // lw then sw under 3 cycles of backpressure
        drive(0, 0, 32'h0, 1);
        drive(0, 1, I_LW, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, I_SW, 0);
            sample();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_lw_held", {out_valid, memtoreg, destreg, memwrite}, {1'b1, 1'b1, 5'd5, 1'b0});
        end
        drive(0, 1, I_SW, 1);
        sample();
        chk("bp_release_ready", in_ready, 1);
        drive(0, 0, 32'h0, 1);
        sample();
        chk("sw_back_to_back", {out_valid, memwrite, memtoreg, regwrite}, {1'b1, 1'b1, 1'b0, 1'b0});

        // bne, jal, illegal opcode, illegal funct
        drive(0, 1, I_BNE, 1);
        drive(0, 1, I_JAL, 1);
        sample();
        chk("bne_fields", {out_valid, isbranch, branchne, alucontrol}, {1'b1, 1'b1, 1'b1, 3'b001});
        drive(0, 1, I_BAD1, 1);
        sample();
        chk("jal_fields", {dojump, link, destreg, regwrite}, {1'b1, 1'b1, 5'd31, 1'b1});
        drive(0, 1, I_BAD2, 1);
        sample();
        chk("illegal_op", {illegal, regwrite, memwrite, dojump, destreg, alucontrol}, {1'b1, 3'b000, 5'd0, 3'b101});
        drive(0, 0, 32'h0, 1);
        sample();
        chk("illegal_funct", {illegal, regwrite, memwrite, dojump, destreg, alucontrol}, {1'b1, 3'b000, 5'd0, 3'b101});

        // Reset two cycles after a mult accept clears the scoreboard
        drive(0, 1, I_MULT, 1);
        drive(0, 0, 32'h0, 1);
        drive(1, 0, 32'h0, 1);
        drive(0, 1, I_MULT, 1);
        sample();
        chk("rst_mid_mult_valid", out_valid, 0);
        chk("rst_mid_mult_ready", in_ready, 1);
        drive(0, 0, 32'h0, 1);
        sample();
        chk("rst_mult_bundle", {out_valid, alucontrol, regwrite}, {1'b1, 3'b100, 1'b0});

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), rand_instr(),
                  ($urandom_range(0, 3) != 0));
        end
        drive(0, 0, 32'h0, 1);
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the MIPS core: accepts one 32-bit instruction per valid/ready handshake and presents a registered control bundle to the execute stage one cycle later. Extends the single-cycle decoder with jr/jal/lui/ori semantics, explicit illegal-instruction flagging instead of don't-cares, branch resolution deferred to execute (`isbranch`/`branchne`), and a multiply scoreboard that stalls `mult`/`mflo`/`mfhi` while a multi-cycle multiply is in flight.

## Interface
- `MULT_CYCLES`, default 4: multiply latency in cycles; range 1..15.
- `LINK_REG`, default 31: destination register for `jal`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage accepts `instr` this cycle.
- `instr`  in  32  instruction word.
- `out_valid`  out  1  control bundle is valid.
- `out_ready`  in  1  execute consumes the bundle.
- `regwrite`, `memwrite`, `memtoreg`, `alusrcbimm`  out  1 each: as in the single-cycle control.
- `isbranch`  out  1  beq/bne; execute branches on `zero ^ branchne`.
- `branchne`  out  1  instruction is bne.
- `dojump`  out  1  absolute jump (j, jal, jr).
- `jumpreg`  out  1  jump target taken from rs (jr).
- `link`  out  1  write PC+4 to `destreg` (jal).
- `luiimm`  out  1  immediate shifted left 16 before the ALU.
- `destreg`  out  5  target register.
- `alucontrol`  out  3  000 slt, 001 sub, 010 mflo, 011 mfhi, 100 mult, 101 add, 110 or, 111 and.
- `illegal`  out  1  unknown opcode or R-type funct.

## Operation
- Accept = `in_valid & in_ready`; on accept all outputs load the decode of `instr` and `out_valid` ← 1; on `out_ready & out_valid` without accept, `out_valid` ← 0.
- `in_ready = (~out_valid | out_ready) & ~stall`; `stall = busy & (instr is mult | mflo | mfhi)`, where `busy = (mcnt != 0)`.
- `mcnt` (4 bits): loads `MULT_CYCLES` on mult accept; otherwise decrements while nonzero, independent of the handshakes.
- R-type (op 000000): `regwrite` 1, `destreg` rd; funct 100001 addu, 100011 subu, 100100 and, 100101 or, 101011 sltu, 011001 mult, 010000 mfhi, 010010 mflo. mult: `regwrite` 0. jr (001000): `dojump` 1, `jumpreg` 1, `regwrite` 0.
- lw 100011: `regwrite` 1, `memtoreg` 1, `alusrcbimm` 1, add, `destreg` rt. sw 101011: `memwrite` 1, `alusrcbimm` 1, add, `regwrite` 0.
- beq 000100 / bne 000101: `isbranch` 1, `branchne` = op[0], sub.
- addiu 001001: add imm; ori 001101: or imm; lui 001111: add imm with `luiimm` 1; all write rt.
- j 000010: `dojump` 1. jal 000011: `dojump` 1, `link` 1, `regwrite` 1, `destreg` = `LINK_REG`.
- Unknown opcode or funct: `illegal` 1, every write/jump/branch output 0, `alucontrol` 101, `destreg` 0. No output is ever X.

## Timing
- Latency 1 cycle from accept to `out_valid`; throughput 1/cycle when unstalled.
- Reset: `out_valid` 0, `mcnt` 0, all control outputs 0, `destreg` 0, `alucontrol` 000. Reset mid-stall or mid-multiply clears everything; `in_ready` is 1 in the cycle after reset.
- mult accepted at cycle t: `mult`/`mflo`/`mfhi` stalled through cycle t+`MULT_CYCLES`, accepted earliest at cycle t+`MULT_CYCLES`+1. Non-multiply instructions are never stalled by `mcnt`.
- Downstream backpressure (`out_ready` 0 with `out_valid` 1) holds every output stable; `in_ready` 0.
- A simultaneous accept and consume replaces the bundle with no bubble.

## Structure
- `decode_pkg`: opcode and funct constants, the `alucontrol` encoding constants, `MULT_CNT_W` = 4.
- Sub-module `mult_scoreboard`: holds `mcnt` and produces `busy`; load and decrement only.
- Decode is combinational in `decode_stage`, feeding the output register.

## Test plan
- `addu $3,$1,$2` (0x00221821) with `out_ready` 1 → next cycle `out_valid` 1, `destreg` 3, `alucontrol` 101, `regwrite` 1, `illegal` 0.
- With `MULT_CYCLES`=4: mult (0x00220019), then mflo $4 (0x00002012) held valid → `in_ready` 0 for 4 cycles, then accepted; bundle shows `alucontrol` 010, `destreg` 4.
- lw (0x8C250004) then sw (0xAC250004) with `out_ready` held 0 for 3 cycles → first bundle stable, `in_ready` 0; releasing `out_ready` gives lw then sw back-to-back.
- bne (0x14220003) → `isbranch` 1, `branchne` 1, `alucontrol` 001. jal (0x0C000010) → `dojump` 1, `link` 1, `destreg` 31, `regwrite` 1.
- Illegal 0x7C000000 and R-type funct 0x3F → `illegal` 1, `regwrite`/`memwrite`/`dojump` 0.
- Assert `reset` 2 cycles after mult accept → `out_valid` 0, `mcnt` 0; mult accepted the cycle after reset deasserts.
